// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: picks the next fetch PC from execute-stage redirects, parks a
// redirect that lands during a fetch stall, and drives the flush/kill pulses.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             IssueTwoF,
  input  logic [1:0]       PCSrcE1,
  input  logic [1:0]       PCSrcE2,
  input  logic [31:0]      PCTargetE1,
  input  logic [31:0]      PCTargetE2,
  input  logic [31:0]      ALUResultE1,
  input  logic [31:0]      ALUResultE2,
  input  logic             ValidE2,
  output logic [31:0]      PCF,
  output logic [31:0]      PCPlus4F,
  output logic             FlushD,
  output logic             FlushE,
  output logic             KillE2,
  output logic             RedirectPending,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic {RUN, HOLD} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        redir1, redir2, redir;
  logic [31:0] target;

  // Code 11 is treated as sequential, so only 01/10 count as a redirect.
  assign redir1 = (PCSrcE1 == 2'b01) || (PCSrcE1 == 2'b10);
  assign redir2 = ValidE2 && ((PCSrcE2 == 2'b01) || (PCSrcE2 == 2'b10)) && !redir1;
  assign redir  = redir1 || redir2;

  always_comb begin
    target = 32'h0;
    if (redir1) begin
      target = (PCSrcE1 == 2'b01) ? PCTargetE1 : {ALUResultE1[31:1], 1'b0};
    end else if (redir2) begin
      target = (PCSrcE2 == 2'b01) ? PCTargetE2 : {ALUResultE2[31:1], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      RUN: begin
        if (redir) begin
          if (!StallF) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = HOLD;
          end
        end else if (!StallF) begin
          pc_d = pc_q + (IssueTwoF ? 32'd8 : 32'd4);
        end
      end
      HOLD: begin
        // A younger redirect supersedes the parked one; no fall-through step.
        if (redir) begin
          pend_d = target;
          if (!StallF) begin
            pc_d    = target;
            state_d = RUN;
          end
        end else if (!StallF) begin
          pc_d    = pend_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redir && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCF             = pc_q;
  assign PCPlus4F        = pc_q + 32'd4;
  assign FlushD          = rst || redir;
  assign FlushE          = rst || redir;
  assign KillE2          = !rst && redir1 && ValidE2;
  assign RedirectPending = !rst && (state_q == HOLD);
  assign RedirectCount   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Vector table for pc_redirect_unit; registered results go through a scoreboard queue.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst, StallF, IssueTwoF, ValidE2;
  logic [1:0]  PCSrcE1, PCSrcE2;
  logic [31:0] PCTargetE1, PCTargetE2, ALUResultE1, ALUResultE2;
  logic [31:0] PCF, PCPlus4F, sPCF, sPCPlus4F;
  logic        FlushD, FlushE, KillE2, RedirectPending;
  logic        sFlushD, sFlushE, sKillE2, sPend;
  logic [15:0] RedirectCount;
  logic [1:0]  sCount;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .StallF(StallF), .IssueTwoF(IssueTwoF),
    .PCSrcE1(PCSrcE1), .PCSrcE2(PCSrcE2), .PCTargetE1(PCTargetE1), .PCTargetE2(PCTargetE2),
    .ALUResultE1(ALUResultE1), .ALUResultE2(ALUResultE2), .ValidE2(ValidE2),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .FlushD(FlushD), .FlushE(FlushE), .KillE2(KillE2),
    .RedirectPending(RedirectPending), .RedirectCount(RedirectCount)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  pc_redirect_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .StallF(StallF), .IssueTwoF(IssueTwoF),
    .PCSrcE1(PCSrcE1), .PCSrcE2(PCSrcE2), .PCTargetE1(PCTargetE1), .PCTargetE2(PCTargetE2),
    .ALUResultE1(ALUResultE1), .ALUResultE2(ALUResultE2), .ValidE2(ValidE2),
    .PCF(sPCF), .PCPlus4F(sPCPlus4F), .FlushD(sFlushD), .FlushE(sFlushE), .KillE2(sKillE2),
    .RedirectPending(sPend), .RedirectCount(sCount)
  );

  typedef struct packed {
    logic        r, stall, two;
    logic [1:0]  s1, s2;
    logic [31:0] t1, a1, t2, a2;
    logic        v2;
    logic        fl, kl;
    logic [31:0] pc;
    logic        pend;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    int          id;
    logic [31:0] pc;
    logic        pend;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEE0;

  // x feeds the source the code selects; the other source carries junk.
  function automatic vec_t mk(logic r, logic stall, logic two,
                              logic [1:0] s1, logic [31:0] x1,
                              logic [1:0] s2, logic [31:0] x2, logic v2,
                              logic fl, logic kl, logic [31:0] pc, logic pend, logic [15:0] cnt);
    vec_t v;
    v.r = r; v.stall = stall; v.two = two; v.s1 = s1; v.s2 = s2; v.v2 = v2;
    v.t1 = (s1 == 2'b10) ? JUNK : x1;
    v.a1 = (s1 == 2'b10) ? x1 : JUNK;
    v.t2 = (s2 == 2'b10) ? JUNK : x2;
    v.a2 = (s2 == 2'b10) ? x2 : JUNK;
    v.fl = fl; v.kl = kl; v.pc = pc; v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d got %h want %h", name, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    rst = v.r; StallF = v.stall; IssueTwoF = v.two; ValidE2 = v.v2;
    PCSrcE1 = v.s1; PCSrcE2 = v.s2;
    PCTargetE1 = v.t1; ALUResultE1 = v.a1; PCTargetE2 = v.t2; ALUResultE2 = v.a2;
    #1;
    chk("FlushD", id, {31'b0, FlushD}, {31'b0, v.fl});
    chk("FlushE", id, {31'b0, FlushE}, {31'b0, v.fl});
    chk("KillE2", id, {31'b0, KillE2}, {31'b0, v.kl});
    if (v.r) chk("PendInRst", id, {31'b0, RedirectPending}, 32'h0);
    sb.push_back('{id: id, pc: v.pc, pend: v.pend, cnt: v.cnt});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty vec%0d got 0 want 1", id);
    end else begin
      e = sb.pop_front();
      chk("PCF", e.id, PCF, e.pc);
      chk("PCPlus4F", e.id, PCPlus4F, e.pc + 32'd4);
      chk("Pending", e.id, {31'b0, RedirectPending}, {31'b0, e.pend});
      chk("Count", e.id, {16'b0, RedirectCount}, {16'b0, e.cnt});
      chk("SatCount", e.id, {30'b0, sCount}, (e.cnt > 16'd3) ? 32'd3 : {16'b0, e.cnt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; StallF = 1'b0; IssueTwoF = 1'b0; ValidE2 = 1'b0;
    PCSrcE1 = 2'b00; PCSrcE2 = 2'b00;
    PCTargetE1 = '0; PCTargetE2 = '0; ALUResultE1 = '0; ALUResultE2 = '0;
    @(posedge clk); #1;

    // Reset: flush asserted, kill suppressed even with a slot-1 redirect present.
    vecs.push_back(mk(1,0,1, 2'b00,0,        2'b00,0,        0, 1,0, 32'h0,        0, 0));
    vecs.push_back(mk(1,0,1, 2'b01,32'h123,  2'b00,0,        1, 1,0, 32'h0,        0, 0));
    // Sequential dual-issue advance.
    vecs.push_back(mk(0,0,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h8,        0, 0));
    vecs.push_back(mk(0,0,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h10,       0, 0));
    vecs.push_back(mk(0,0,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h18,       0, 0));
    // Slot 1 beats slot 2; slot 2 killed.
    vecs.push_back(mk(0,0,1, 2'b01,32'h100,  2'b10,32'h5000, 1, 1,1, 32'h100,      0, 1));
    // Slot-2 jalr, bit 0 cleared; then invalid slot 2 is ignored.
    vecs.push_back(mk(0,0,0, 2'b00,0,        2'b10,32'h2003, 1, 1,0, 32'h2002,     0, 2));
    vecs.push_back(mk(0,0,0, 2'b00,0,        2'b10,32'h2003, 0, 0,0, 32'h2006,     0, 2));
    vecs.push_back(mk(0,0,1, 2'b11,32'h7777, 2'b00,0,        0, 0,0, 32'h200E,     0, 2));
    // Slot-1 jalr keeps bit 1.
    vecs.push_back(mk(0,0,1, 2'b10,32'h3003, 2'b00,0,        0, 1,0, 32'h3002,     0, 3));
    vecs.push_back(mk(0,1,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h3002,     0, 3));
    // Redirect during stall parks; released without fall-through increment.
    vecs.push_back(mk(0,1,1, 2'b01,32'h400,  2'b00,0,        0, 1,0, 32'h3002,     1, 4));
    vecs.push_back(mk(0,1,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h3002,     1, 4));
    vecs.push_back(mk(0,1,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h3002,     1, 4));
    vecs.push_back(mk(0,0,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h400,      0, 4));
    // Overwrite in HOLD, then release.
    vecs.push_back(mk(0,1,1, 2'b01,32'h600,  2'b00,0,        0, 1,0, 32'h400,      1, 5));
    vecs.push_back(mk(0,1,1, 2'b00,0,        2'b01,32'h700,  1, 1,0, 32'h400,      1, 6));
    vecs.push_back(mk(0,0,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h700,      0, 6));
    // New redirect in HOLD with stall clear goes straight to PCF.
    vecs.push_back(mk(0,1,1, 2'b01,32'h800,  2'b00,0,        1, 1,1, 32'h700,      1, 7));
    vecs.push_back(mk(0,0,1, 2'b01,32'h900,  2'b00,0,        0, 1,0, 32'h900,      0, 8));
    // Wrap-around.
    vecs.push_back(mk(0,0,1, 2'b01,32'hFFFF_FFFC, 2'b00,0,   0, 1,0, 32'hFFFF_FFFC, 0, 9));
    vecs.push_back(mk(0,0,1, 2'b00,0,        2'b00,0,        0, 0,0, 32'h4,        0, 9));
    vecs.push_back(mk(0,0,0, 2'b00,0,        2'b00,0,        0, 0,0, 32'h8,        0, 9));

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset while a redirect to 0x800 is parked: it must never reach PCF.
    apply(mk(0,1,1, 2'b01,32'h800, 2'b00,0, 0, 1,0, 32'h8, 1, 10), 100);
    apply(mk(1,1,1, 2'b00,0,       2'b00,0, 0, 1,0, 32'h0, 0, 0),  101);
    apply(mk(0,0,0, 2'b00,0,       2'b00,0, 0, 0,0, 32'h4, 0, 0),  102);
    apply(mk(0,0,0, 2'b00,0,       2'b00,0, 0, 0,0, 32'h8, 0, 0),  103);

    chk("sb_drained", 999, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
